exp_sigma_core: RTL and testbench

- Arithmetic and control core of the exp(x·sigma) table generator. Three independent functions share one clock and reset:
  - a pipelined fixed-point exponential of a fractional argument;
  - a 3-bit-addressed integer-exponent ROM;
  - a set/reset enable latch that gates the generator sweep.
- Parent logic computes exp(x·sigma) as exp(frac) × exp(int) from two of these results.

---
 rtl/exp_sigma_core.sv | 132 +++++++++++++
 tb/tb_exp_sigma_core.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/exp_sigma_core.sv
// Arithmetic and control core of the exp(x*sigma) table generator.
// Three independent functions on one clock/reset:
//   - 3-stage pipelined e^f for an 18-bit fraction f (result 4.18 unsigned)
//   - 8-entry integer-exponent ROM e^(a-2) (result 3.10 unsigned, saturating)
//   - set/reset enable latch with clear dominating set
// e^f = e^(f_hi/64) * e^(r), where f_hi is the top 6 bits of f and r is the
// low 12 bits scaled by 2^-18 (so r < 2^-6). The second factor uses the
// polynomial 1 + r + r^2/2; its truncation error (about r^3/6) stays well
// under one output LSB.
module exp_sigma_core (
    input  logic        CLK,
    input  logic        RST,
    input  logic [17:0] iFrac,
    output logic [21:0] oExpFrac,
    input  logic [2:0]  iIntAddr,
    output logic [12:0] oExpInt,
    input  logic        iSet,
    input  logic        iClr,
    output logic        oEnable
);

    // Segment value round(e^(k/64) * 2^22), evaluated at elaboration time.
    // A Taylor series with a 40-bit fraction keeps the rounding exact.
    // Four extra fraction bits beyond the output keep the segment seams
    // monotonic after the final rounding.
    function automatic logic [23:0] exp_seg(input int k);
        logic [127:0] x;
        logic [127:0] term;
        logic [127:0] sum;
        x    = 128'(k) << 34;
        term = 128'd1 << 40;
        sum  = term;
        for (int n = 1; n < 24; n++) begin
            term = ((term * x) >> 40) / 128'(n);
            sum  = sum + term;
        end
        return 24'((sum + (128'd1 << 17)) >> 18);
    endfunction

    logic [23:0] seg_rom [64];

    for (genvar gi = 0; gi < 64; gi++) begin : g_seg
        localparam logic [23:0] SEG_VAL = exp_seg(gi);
        assign seg_rom[gi] = SEG_VAL;
    end

    // Pipeline state: stage 1 holds the segment value and the residual.
    // Stage 2 holds the segment value and the polynomial. Stage 3 holds the
    // rounded product.
    logic [23:0] tab_reg;
    logic [11:0] r_reg;
    logic [23:0] tab2_reg;
    logic [24:0] poly_reg;
    logic [21:0] exp_frac_reg;

    logic [23:0] r_sq;
    logic [24:0] poly_next;
    logic [48:0] prod;
    logic [21:0] exp_frac_next;

    // Polynomial 1 + r + r^2/2 at 2^-24 scale, and the final product
    // rounded from 2^-46 down to 2^-18.
    always_comb begin
        r_sq          = 24'(r_reg) * 24'(r_reg);
        poly_next     = 25'h100_0000 + 25'({r_reg, 6'd0}) + 25'((r_sq + 24'd4096) >> 13);
        prod          = 49'(tab2_reg) * 49'(poly_reg);
        exp_frac_next = 22'((prod + (49'd1 << 27)) >> 28);
    end

    // Exponential pipeline registers. Reset flushes every stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tab_reg      <= '0;
            r_reg        <= '0;
            tab2_reg     <= '0;
            poly_reg     <= '0;
            exp_frac_reg <= '0;
        end else begin
            tab_reg      <= seg_rom[iFrac[17:12]];
            r_reg        <= iFrac[11:0];
            tab2_reg     <= tab_reg;
            poly_reg     <= poly_next;
            exp_frac_reg <= exp_frac_next;
        end
    end

    assign oExpFrac = exp_frac_reg;

    logic [12:0] exp_int_reg;
    logic [12:0] exp_int_next;

    // Integer-exponent table, round(e^(a-2) * 2^10). The entries for e^3
    // and above do not fit 3 integer bits, so they clamp to full scale.
    always_comb begin
        exp_int_next = 13'd8191;
        case (iIntAddr)
            3'd0:    exp_int_next = 13'd139;
            3'd1:    exp_int_next = 13'd377;
            3'd2:    exp_int_next = 13'd1024;
            3'd3:    exp_int_next = 13'd2784;
            3'd4:    exp_int_next = 13'd7566;
            default: exp_int_next = 13'd8191;
        endcase
    end

    // Registered ROM read, with one-cycle latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            exp_int_reg <= '0;
        end else begin
            exp_int_reg <= exp_int_next;
        end
    end

    assign oExpInt = exp_int_reg;

    logic enable_reg;

    // Sweep enable latch: clear wins over set, otherwise hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            enable_reg <= 1'b0;
        end else if (iClr) begin
            enable_reg <= 1'b0;
        end else if (iSet) begin
            enable_reg <= 1'b1;
        end
    end

    assign oEnable = enable_reg;

endmodule

// File: tb/tb_exp_sigma_core.sv
// Scoreboard bench for exp_sigma_core. Every cycle, the bench drives stimulus
// and queues the expected exponential (due 3 edges later), ROM word and latch
// state (due 1 edge later). A negedge checker compares the queued entries
// that are due against the outputs.
module tb_exp_sigma_core;

    logic        CLK;
    logic        RST;
    logic [17:0] iFrac;
    logic [21:0] oExpFrac;
    logic [2:0]  iIntAddr;
    logic [12:0] oExpInt;
    logic        iSet;
    logic        iClr;
    logic        oEnable;

    exp_sigma_core dut (
        .CLK      (CLK),
        .RST      (RST),
        .iFrac    (iFrac),
        .oExpFrac (oExpFrac),
        .iIntAddr (iIntAddr),
        .oExpInt  (oExpInt),
        .iSet     (iSet),
        .iClr     (iClr),
        .oEnable  (oEnable)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int due;
        int kind;   // 0 exponential, 1 rom, 2 enable
        int val;
        int tol;
        int mono;   // 0 none, 1 compare with previous, 2 first of a sweep
    } sb_t;

    sb_t sb[$];
    int  edge_cnt = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  prev_sweep = 0;
    bit  en_model = 1'b0;
    int  rom_model [8] = '{139, 377, 1024, 2784, 7566, 8191, 8191, 8191};
    int  stream_frac [5] = '{0, 65536, 131072, 196608, 262143};
    int  stream_want [5] = '{262144, 336600, 432202, 554962, 712579};

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input int obs, input int expv, input int tol);
        int d;
        n_cmp++;
        d = obs - expv;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d (tol %0d)", tag, edge_cnt, obs, expv, tol);
        end
    endtask

    function automatic int ideal(input int f);
        real e;
        e = $exp(real'(f) / 262144.0);
        return $rtoi(e * 262144.0 + 0.5);
    endfunction

    task automatic push(input int due, input int kind, input int val, input int tol, input int mono);
        sb_t e;
        e.due = due; e.kind = kind; e.val = val; e.tol = tol; e.mono = mono;
        sb.push_back(e);
    endtask

    // One stimulus cycle. A negative want means the ideal e^f is used.
    task automatic drive(input int f, input int a, input bit s, input bit c, input int want, input int mono);
        @(posedge CLK); #1;
        RST = 1'b0; iFrac = 18'(f); iIntAddr = 3'(a); iSet = s; iClr = c;
        push(edge_cnt + 3, 0, (want < 0) ? ideal(f) : want, 16, mono);
        push(edge_cnt + 1, 1, rom_model[a], 0, 0);
        if (c) en_model = 1'b0;
        else if (s) en_model = 1'b1;
        push(edge_cnt + 1, 2, int'(en_model), 0, 0);
        $display("cycle %0d: frac=%0d addr=%0d set=%0d clr=%0d", edge_cnt, f, a, s, c);
    endtask

    // Reset cycles with busy inputs. These inputs must have no effect.
    // Results still in flight are dropped from the scoreboard.
    task automatic do_reset(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            RST = 1'b1; iFrac = 18'($urandom_range(1, 262143)); iIntAddr = 3'($urandom_range(0, 7));
            iSet = 1'b1; iClr = 1'b0;
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].due > edge_cnt) sb.delete(i);
            push(edge_cnt + 1, 0, 0, 0, 0);
            push(edge_cnt + 2, 0, 0, 0, 0);
            push(edge_cnt + 3, 0, 0, 0, 0);
            push(edge_cnt + 1, 1, 0, 0, 0);
            push(edge_cnt + 1, 2, 0, 0, 0);
            en_model = 1'b0;
            $display("cycle %0d: reset", edge_cnt);
        end
    endtask

    // Compare every scoreboard entry that falls due on this edge.
    always @(negedge CLK) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == edge_cnt) begin
                case (sb[i].kind)
                    0: begin
                        check("exp", int'(oExpFrac), sb[i].val, sb[i].tol);
                        check("exp_msb", int'(oExpFrac[21:20]), 0, 0);
                        if (sb[i].mono == 1)
                            check("exp_mono", (int'(oExpFrac) >= prev_sweep) ? 1 : 0, 1, 0);
                        if (sb[i].mono != 0)
                            prev_sweep = int'(oExpFrac);
                    end
                    1: check("rom", int'(oExpInt), sb[i].val, 0);
                    default: check("enable", int'(oEnable), sb[i].val, 0);
                endcase
                sb.delete(i);
            end else if (sb[i].due < edge_cnt) begin
                check("stale", sb[i].due, edge_cnt, 0);
                sb.delete(i);
            end
        end
    end

    initial begin
        RST = 1'b1; iFrac = '0; iIntAddr = '0; iSet = 1'b0; iClr = 1'b0;
        do_reset(2);

        // Reference stream together with the ROM sweep.
        for (int i = 0; i < 8; i++) begin
            if (i < 5) drive(stream_frac[i], i, 1'b0, 1'b0, stream_want[i], 0);
            else       drive(0, i, 1'b0, 1'b0, 262144, 0);
        end

        // Latch: set pulse and hold, clear pulse, simultaneous set/clear,
        // held set across a clear pulse.
        drive(1000, 2, 1'b1, 1'b0, -1, 0);
        repeat (3) drive(2000, 3, 1'b0, 1'b0, -1, 0);
        drive(3000, 4, 1'b0, 1'b1, -1, 0);
        repeat (2) drive(4000, 1, 1'b0, 1'b0, -1, 0);
        drive(5000, 0, 1'b1, 1'b0, -1, 0);
        drive(6000, 0, 1'b1, 1'b1, -1, 0);
        drive(7000, 0, 1'b0, 1'b0, -1, 0);
        drive(8000, 5, 1'b1, 1'b0, -1, 0);
        drive(9000, 6, 1'b1, 1'b1, -1, 0);
        repeat (3) drive(10000, 7, 1'b1, 1'b0, -1, 0);
        drive(11000, 2, 1'b0, 1'b0, -1, 0);

        // Reset with the pipeline full of nonzero data.
        for (int i = 0; i < 6; i++)
            drive($urandom_range(1, 262143), i, (i == 0), 1'b0, -1, 0);
        do_reset(1);
        for (int i = 0; i < 4; i++)
            drive(50000 + i * 40000, 4, 1'b0, 1'b0, -1, 0);
        drive(123456, 3, 1'b1, 1'b0, -1, 0);
        drive(0, 3, 1'b0, 1'b0, -1, 0);

        // Accuracy/monotonic sweep: values go 0,7,8,15,..., so both sides
        // of every segment boundary and the top code 262143 are included.
        for (int i = 0; i < 65536; i++)
            drive(4 * i + 3 * (i & 1), i % 8, 1'b0, 1'b0, -1, (i == 0) ? 2 : 1);

        repeat (3) drive(0, 0, 1'b0, 1'b0, -1, 0);
        repeat (4) @(posedge CLK);
        @(negedge CLK); #1;
        check("drain", sb.size(), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
